// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: FSM state encoding and word geometry.
package program_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_RUN,
    ST_ERROR
  } state_t;

  function automatic logic is_load_state(input state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Assembles a big-endian instruction word from two consecutive accepted bytes.
module program_loader_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int unsigned WORD_W = BYTE_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_hi,
  input  logic              load_lo,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (load_hi) begin
      word[WORD_W-1 -: BYTE_W] <= byte_data;
    end else if (load_lo) begin
      word[BYTE_W-1:0] <= byte_data;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: reads a word count and big-endian words, writes
// them to code memory from address 0, then enables the processor.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr,
  output logic [WORD_W-1:0] code_data,
  output logic              run,
  output logic              busy,
  output logic              error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(32'd1 << ADDR_W);

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   written;
  logic [CNT_W-1:0]   written_inc;
  logic [ADDR_W-1:0]  addr_q;
  logic               error_q;
  logic               xfer;
  logic               accept;
  logic [16:0]        cnt_full;
  logic               cnt_bad;

  assign xfer        = byte_valid && byte_ready;
  assign accept      = xfer && !abort && !load_start;
  assign written_inc = written + CNT_W'(1'b1);

  // The high count byte carries every bit above bit 7, so a full 512-word image
  // (0x00,0x02) is expressible; anything beyond the address space is rejected.
  assign cnt_full = {1'b0, byte_data, count[7:0]};
  assign cnt_bad  = (cnt_full == 17'd0) || (cnt_full > MAX_WORDS);

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    code_w_en  = 1'b0;
    run        = 1'b0;
    busy       = is_load_state(state);
    case (state)
      ST_IDLE:    state_next = state;
      ST_CNT_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_next = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_next = cnt_bad ? ST_ERROR : ST_DATA_HI;
      end
      ST_DATA_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_next = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        code_w_en  = !abort;
        state_next = (written_inc == count) ? ST_RUN : ST_DATA_HI;
      end
      ST_RUN:     run = 1'b1;
      ST_ERROR:   state_next = state;
      default:    state_next = ST_IDLE;
    endcase
    if (load_start) state_next = ST_CNT_LO;
    if (abort)      state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      written <= '0;
      addr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state <= state_next;
      if (!abort) begin
        if (load_start) begin
          count   <= '0;
          written <= '0;
          addr_q  <= '0;
          error_q <= 1'b0;
        end else begin
          case (state)
            ST_CNT_LO: if (accept) count <= CNT_W'(byte_data);
            ST_CNT_HI: begin
              if (accept) begin
                count <= CNT_W'(cnt_full);
                if (cnt_bad) error_q <= 1'b1;
              end
            end
            ST_WRITE: begin
              addr_q  <= addr_q + ADDR_W'(1'b1);
              written <= written_inc;
            end
            default: ;
          endcase
        end
      end
    end
  end

  program_loader_byte_assembler #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_hi   (accept && (state == ST_DATA_HI)),
    .load_lo   (accept && (state == ST_DATA_LO)),
    .byte_data (byte_data),
    .word      (code_data)
  );

  assign code_addr = addr_q;
  assign error     = error_q;

endmodule
